// File: rtl/l2_request_responder.sv
// L2 request responder: queued single/burst read and write requests serviced in order against a
// single-port backing memory. Define L2_RESPONDER_RESERVATION_EN to add LR/SC reservation support.

module l2_responder_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign head    = storage[rd_ptr];

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CNT_ONE;
        end else if (do_pop && !do_push) begin
            count_next = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_next;
            full  <= (count_next == CNT_FULL);
        end
    end

    // NOTE: storage arrays are not reset; occupancy is tracked by the reset pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr] <= push_data;
    end
endmodule

module l2_request_responder #(
    parameter int REQ_FIFO_DEPTH   = 4,
    parameter int WDATA_FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] addr,
    input  logic [3:0]  be,
    input  logic        rnw,
    input  logic        is_amo,
    input  logic [4:0]  amo_type_or_burst_size,
    input  logic [1:0]  sub_id,
    input  logic        request_push,
    output logic        request_full,
    input  logic [31:0] wr_data,
    input  logic        wr_data_push,
    output logic        data_full,
    output logic [31:0] rd_data,
    output logic [1:0]  rd_sub_id,
    output logic        rd_data_valid,
    input  logic        rd_data_ack,
    output logic        con_result,
    output logic        con_valid,
    output logic        mem_en,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  be;
        logic        rnw;
        logic        is_amo;
        logic [4:0]  amo_type_or_burst_size;
        logic [1:0]  sub_id;
    } req_t;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t      state;
    req_t        req_in;
    req_t        req_head;
    logic        req_empty;
    logic        req_pop;
    logic [31:0] wd_head;
    logic        wd_empty;
    logic        wd_pop;

    logic [29:0] cur_addr;
    logic [3:0]  cur_be;
    logic [1:0]  cur_sub_id;
    logic        cur_single;
    logic [5:0]  beats_left;
    logic [5:0]  head_len;
    logic        rd_pending;
    logic        rd_issue;
    logic        wr_issue;

    logic [31:0] obuf_data [2];
    logic [1:0]  obuf_sub  [2];
    logic        obuf_wr;
    logic        obuf_rd;
    logic [1:0]  obuf_count;
    logic        obuf_pop;
    logic [2:0]  rd_load;

    assign req_in = '{addr: addr, be: be, rnw: rnw, is_amo: is_amo,
                      amo_type_or_burst_size: amo_type_or_burst_size, sub_id: sub_id};

    l2_responder_fifo #(.WIDTH($bits(req_t)), .DEPTH(REQ_FIFO_DEPTH)) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (request_push),
        .push_data (req_in),
        .pop       (req_pop),
        .head      (req_head),
        .empty     (req_empty),
        .full      (request_full)
    );

    l2_responder_fifo #(.WIDTH(32), .DEPTH(WDATA_FIFO_DEPTH)) u_wdata_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_data_push),
        .push_data (wr_data),
        .pop       (wd_pop),
        .head      (wd_head),
        .empty     (wd_empty),
        .full      (data_full)
    );

    // Atomic requests are always a single beat regardless of the shared type/size field.
    assign head_len = req_head.is_amo ? 6'd1 : ({1'b0, req_head.amo_type_or_burst_size} + 6'd1);
    assign req_pop  = (state == IDLE) && !req_empty;
    assign wd_pop   = (state == WRITE) && !wd_empty;

    // Reads may run ahead only while the captured-plus-in-flight words fit the 2-entry buffer.
    assign obuf_pop = (obuf_count != 2'd0) && rd_data_ack;
    assign rd_load  = {1'b0, obuf_count} + {2'b00, rd_pending} - {2'b00, obuf_pop};
    assign rd_issue = (state == READ) && (beats_left != 6'd0) && (rd_load < 3'd2);

`ifdef L2_RESPONDER_RESERVATION_EN
    logic        res_valid;
    logic [29:0] res_addr;
    logic        cur_sc;
    logic        sc_match;
    logic        head_lr;
    logic        head_sc;

    assign head_lr  = req_head.is_amo && req_head.rnw && (req_head.amo_type_or_burst_size == 5'b00010);
    assign head_sc  = req_head.is_amo && !req_head.rnw && (req_head.amo_type_or_burst_size == 5'b00011);
    assign sc_match = res_valid && (res_addr == cur_addr);
    // A failing store-conditional still consumes its data word but never reaches memory.
    assign wr_issue = wd_pop && (!cur_sc || sc_match);
`else
    assign wr_issue   = wd_pop;
    assign con_valid  = 1'b0;
    assign con_result = 1'b0;
`endif

    assign mem_en    = rd_issue || wr_issue;
    assign mem_we    = wr_issue;
    assign mem_addr  = cur_addr;
    assign mem_be    = wr_issue ? (cur_single ? cur_be : 4'hF) : 4'h0;
    assign mem_wdata = wr_issue ? wd_head : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur_addr   <= '0;
            cur_be     <= '0;
            cur_sub_id <= '0;
            cur_single <= 1'b0;
            beats_left <= '0;
            rd_pending <= 1'b0;
`ifdef L2_RESPONDER_RESERVATION_EN
            res_valid  <= 1'b0;
            res_addr   <= '0;
            cur_sc     <= 1'b0;
            con_valid  <= 1'b0;
            con_result <= 1'b0;
`endif
        end else begin
            rd_pending <= rd_issue;
`ifdef L2_RESPONDER_RESERVATION_EN
            con_valid  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!req_empty) begin
                        cur_addr   <= req_head.addr;
                        cur_be     <= req_head.be;
                        cur_sub_id <= req_head.sub_id;
                        cur_single <= (head_len == 6'd1);
                        beats_left <= head_len;
                        state      <= req_head.rnw ? READ : WRITE;
`ifdef L2_RESPONDER_RESERVATION_EN
                        cur_sc     <= head_sc;
                        if (head_lr) begin
                            res_valid <= 1'b1;
                            res_addr  <= req_head.addr;
                        end
`endif
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        cur_addr   <= cur_addr + 30'd1;
                        beats_left <= beats_left - 6'd1;
                    end else if (beats_left == 6'd0 && rd_pending) begin
                        // The final word is captured into the buffer on this same edge.
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    if (wd_pop) begin
                        cur_addr   <= cur_addr + 30'd1;
                        beats_left <= beats_left - 6'd1;
                        if (beats_left == 6'd1) state <= IDLE;
`ifdef L2_RESPONDER_RESERVATION_EN
                        if (cur_sc) begin
                            con_valid  <= 1'b1;
                            con_result <= sc_match;
                            res_valid  <= 1'b0;
                        end else if (res_valid && res_addr == cur_addr) begin
                            res_valid  <= 1'b0;
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            obuf_wr    <= 1'b0;
            obuf_rd    <= 1'b0;
            obuf_count <= 2'd0;
        end else begin
            if (rd_pending) obuf_wr <= !obuf_wr;
            if (obuf_pop)   obuf_rd <= !obuf_rd;
            case ({rd_pending, obuf_pop})
                2'b10:   obuf_count <= obuf_count + 2'd1;
                2'b01:   obuf_count <= obuf_count - 2'd1;
                default: obuf_count <= obuf_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rd_pending) begin
            obuf_data[obuf_wr] <= mem_rdata;
            obuf_sub[obuf_wr]  <= cur_sub_id;
        end
    end

    assign rd_data_valid = (obuf_count != 2'd0);
    assign rd_data       = rd_data_valid ? obuf_data[obuf_rd] : 32'h0;
    assign rd_sub_id     = rd_data_valid ? obuf_sub[obuf_rd] : 2'd0;
endmodule

// File: tb/tb_l2_request_responder.sv
// Directed bench for l2_request_responder: table of single-request transactions plus hand-written
// sequences for back-pressure, queue-full, late write data, reservations and mid-burst reset.
module tb_l2_request_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] addr;
    logic [3:0]  be;
    logic        rnw;
    logic        is_amo;
    logic [4:0]  amo_type_or_burst_size;
    logic [1:0]  sub_id;
    logic        request_push;
    logic        request_full;
    logic [31:0] wr_data;
    logic        wr_data_push;
    logic        data_full;
    logic [31:0] rd_data;
    logic [1:0]  rd_sub_id;
    logic        rd_data_valid;
    logic        rd_data_ack;
    logic        con_result;
    logic        con_valid;
    logic        mem_en;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    l2_request_responder dut (
        .clk(clk), .rst(rst), .addr(addr), .be(be), .rnw(rnw), .is_amo(is_amo),
        .amo_type_or_burst_size(amo_type_or_burst_size), .sub_id(sub_id),
        .request_push(request_push), .request_full(request_full),
        .wr_data(wr_data), .wr_data_push(wr_data_push), .data_full(data_full),
        .rd_data(rd_data), .rd_sub_id(rd_sub_id), .rd_data_valid(rd_data_valid),
        .rd_data_ack(rd_data_ack), .con_result(con_result), .con_valid(con_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] rd_val(input logic [29:0] a);
        return 32'h5A00_0000 ^ {2'b00, a};
    endfunction

    // Backing memory: synchronous read, data valid the cycle after the access.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= rd_val(mem_addr);
    end

    typedef struct { logic [29:0] addr; logic [3:0] be; logic [31:0] data; int cyc; } acc_t;
    typedef struct { logic [31:0] data; logic [1:0] sub; } word_t;
    acc_t  rd_log[$];
    acc_t  wr_log[$];
    word_t word_log[$];
    int    issued, consumed, max_outstanding, con_pulses;
    logic  last_con_result;
    logic  hold_prev;
    logic [31:0] hold_data;
    logic [1:0]  hold_sub;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", {31'b0, rd_data_valid}, 32'd1);
                check("hold_data", rd_data, hold_data);
                check("hold_sub", {30'b0, rd_sub_id}, {30'b0, hold_sub});
            end
            if (mem_en && !mem_we) begin
                rd_log.push_back('{addr: mem_addr, be: 4'h0, data: 32'h0, cyc: cycle});
                issued++;
            end
            if (mem_en && mem_we)
                wr_log.push_back('{addr: mem_addr, be: mem_be, data: mem_wdata, cyc: cycle});
            if (rd_data_valid && rd_data_ack) begin
                word_log.push_back('{data: rd_data, sub: rd_sub_id});
                consumed++;
            end
            if (issued - consumed > max_outstanding) max_outstanding = issued - consumed;
            if (con_valid) begin
                con_pulses++;
                last_con_result = con_result;
            end
            hold_prev = rd_data_valid && !rd_data_ack;
            hold_data = rd_data;
            hold_sub  = rd_sub_id;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_log.delete();
        word_log.delete();
        issued = 0;
        consumed = 0;
        max_outstanding = 0;
        con_pulses = 0;
        last_con_result = 1'b0;
    endtask

    task automatic push_req(input logic rnw_i, input logic amo_i, input logic [29:0] a,
                            input logic [4:0] bs, input logic [3:0] be_i, input logic [1:0] sid);
        rnw = rnw_i; is_amo = amo_i; addr = a; amo_type_or_burst_size = bs; be = be_i; sub_id = sid;
        request_push = 1'b1;
        tick();
        request_push = 1'b0;
    endtask

    task automatic push_data(input logic [31:0] d);
        wr_data = d;
        wr_data_push = 1'b1;
        tick();
        wr_data_push = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        rnw;
        logic        amo;
        logic [29:0] a;
        logic [4:0]  bs;
        logic [3:0]  be;
        logic [1:0]  sid;
        int          exp_n;
        logic [29:0] exp_first;
        logic [29:0] exp_last;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"rd_burst8", 1'b1, 1'b0, 30'h100,      5'd7,      4'hF, 2'd2, 8,  30'h100,      30'h107,  4'h0};
        vecs[1] = '{"rd_wrap",   1'b1, 1'b0, 30'h3FFFFFFE, 5'd3,      4'hF, 2'd1, 4,  30'h3FFFFFFE, 30'h1,    4'h0};
        vecs[2] = '{"wr_single", 1'b0, 1'b0, 30'h20,       5'd0,      4'hA, 2'd0, 1,  30'h20,       30'h20,   4'hA};
        vecs[3] = '{"wr_burst4", 1'b0, 1'b0, 30'h200,      5'd3,      4'h1, 2'd0, 4,  30'h200,      30'h203,  4'hF};
        vecs[4] = '{"rd_single", 1'b1, 1'b0, 30'h55,       5'd0,      4'hF, 2'd3, 1,  30'h55,       30'h55,   4'h0};
        vecs[5] = '{"rd_max32",  1'b1, 1'b0, 30'h1000,     5'd31,     4'hF, 2'd0, 32, 30'h1000,     30'h101F, 4'h0};
        vecs[6] = '{"rd_amo",    1'b1, 1'b1, 30'h40,       5'b00010,  4'hF, 2'd1, 1,  30'h40,       30'h40,   4'h0};
        vecs[7] = '{"wr_amo",    1'b0, 1'b1, 30'h60,       5'b00111,  4'h6, 2'd0, 1,  30'h60,       30'h60,   4'h6};

        rst = 1'b1;
        addr = '0; be = '0; rnw = 1'b0; is_amo = 1'b0; amo_type_or_burst_size = '0; sub_id = '0;
        request_push = 1'b0; wr_data = '0; wr_data_push = 1'b0; rd_data_ack = 1'b1;
        clear_logs();
        run(2);
        check("reset_ctrl", {25'b0, rd_data_valid, mem_en, mem_we, request_full, data_full, con_valid, con_result}, 32'h0);
        check("reset_rd_data", rd_data, 32'h0);
        check("reset_mem_addr", {2'b0, mem_addr}, 32'h0);
        rst = 1'b0;
        run(2);

        // Single-request transactions.
        for (int v = 0; v < 8; v++) begin
            logic ok;
            logic [31:0] base;
            int n;
            clear_logs();
            base = 32'hC000_0000 | (v << 8);
            if (!vecs[v].rnw)
                for (int i = 0; i < vecs[v].exp_n; i++) push_data(base + i);
            push_req(vecs[v].rnw, vecs[v].amo, vecs[v].a, vecs[v].bs, vecs[v].be, vecs[v].sid);
            run(50);
            ok = 1'b1;
            if (vecs[v].rnw) begin
                n = rd_log.size();
                check($sformatf("%s_reads", vecs[v].name), n, vecs[v].exp_n);
                check($sformatf("%s_words", vecs[v].name), word_log.size(), vecs[v].exp_n);
                if (n > 0 && word_log.size() == n) begin
                    check($sformatf("%s_first", vecs[v].name), {2'b0, rd_log[0].addr}, {2'b0, vecs[v].exp_first});
                    check($sformatf("%s_last", vecs[v].name), {2'b0, rd_log[n-1].addr}, {2'b0, vecs[v].exp_last});
                    check($sformatf("%s_consec", vecs[v].name), rd_log[n-1].cyc - rd_log[0].cyc, n - 1);
                    for (int i = 0; i < n; i++) begin
                        if (rd_log[i].addr != 30'(vecs[v].exp_first + 30'(i))) ok = 1'b0;
                        if (word_log[i].data != rd_val(30'(vecs[v].exp_first + 30'(i)))) ok = 1'b0;
                        if (word_log[i].sub != vecs[v].sid) ok = 1'b0;
                    end
                    check($sformatf("%s_order_data_tag", vecs[v].name), {31'b0, ok}, 32'd1);
                end
            end else begin
                n = wr_log.size();
                check($sformatf("%s_writes", vecs[v].name), n, vecs[v].exp_n);
                if (n > 0) begin
                    check($sformatf("%s_last", vecs[v].name), {2'b0, wr_log[n-1].addr}, {2'b0, vecs[v].exp_last});
                    for (int i = 0; i < n; i++) begin
                        if (wr_log[i].addr != 30'(vecs[v].exp_first + 30'(i))) ok = 1'b0;
                        if (wr_log[i].be != vecs[v].exp_be) ok = 1'b0;
                        if (wr_log[i].data != base + i) ok = 1'b0;
                    end
                    check($sformatf("%s_addr_be_data", vecs[v].name), {31'b0, ok}, 32'd1);
                end
            end
        end

        // Back-pressure: ack low for 3 cycles once the first word of a 4-beat read appears.
        clear_logs();
        rd_data_ack = 1'b0;
        push_req(1'b1, 1'b0, 30'h300, 5'd3, 4'hF, 2'd1);
        for (int i = 0; i < 20 && !rd_data_valid; i++) tick();
        check("bp_first_valid", {31'b0, rd_data_valid}, 32'd1);
        run(3);
        rd_data_ack = 1'b1;
        run(20);
        check("bp_words", word_log.size(), 4);
        check("bp_max_inflight", max_outstanding, 2);
        if (word_log.size() == 4) begin
            logic ok = 1'b1;
            for (int i = 0; i < 4; i++)
                if (word_log[i].data != rd_val(30'h300 + 30'(i)) || word_log[i].sub != 2'd1) ok = 1'b0;
            check("bp_order", {31'b0, ok}, 32'd1);
        end

        // Request queue full: a stalled write keeps the FSM busy while five reads are pushed.
        clear_logs();
        push_req(1'b0, 1'b0, 30'h500, 5'd0, 4'hF, 2'd0);
        run(3);
        for (int i = 0; i < 3; i++) push_req(1'b1, 1'b0, 30'h600 + 30'(i), 5'd0, 4'hF, 2'(i));
        check("full_after3", {31'b0, request_full}, 32'd0);
        push_req(1'b1, 1'b0, 30'h603, 5'd0, 4'hF, 2'd3);
        check("full_after4", {31'b0, request_full}, 32'd1);
        push_req(1'b1, 1'b0, 30'h604, 5'd0, 4'hF, 2'd0);
        check("full_after5", {31'b0, request_full}, 32'd1);
        push_data(32'h1234_5678);
        run(40);
        check("full_writes", wr_log.size(), 1);
        if (wr_log.size() == 1) check("full_wdata", wr_log[0].data, 32'h1234_5678);
        check("full_reads", rd_log.size(), 4);
        check("full_words", word_log.size(), 4);
        if (rd_log.size() == 4) check("full_last_addr", {2'b0, rd_log[3].addr}, 32'h603);
        check("full_cleared", {31'b0, request_full}, 32'd0);

        // Write-data queue full: ninth word is dropped, an 8-beat write drains exactly eight.
        clear_logs();
        for (int i = 0; i < 7; i++) push_data(32'hE000_0000 + i);
        check("dfull_after7", {31'b0, data_full}, 32'd0);
        push_data(32'hE000_0007);
        check("dfull_after8", {31'b0, data_full}, 32'd1);
        push_data(32'hE000_00FF);
        push_req(1'b0, 1'b0, 30'h700, 5'd7, 4'h3, 2'd0);
        run(30);
        check("dfull_writes", wr_log.size(), 8);
        if (wr_log.size() == 8) begin
            check("dfull_last_data", wr_log[7].data, 32'hE000_0007);
            check("dfull_last_addr", {2'b0, wr_log[7].addr}, 32'h707);
            check("dfull_be", {28'b0, wr_log[0].be}, 32'hF);
        end
        check("dfull_cleared", {31'b0, data_full}, 32'd0);

        // Late write data at the top of the address space, then a wrapping 2-beat write.
        clear_logs();
        push_req(1'b0, 1'b0, 30'h3FFFFFFF, 5'd0, 4'b0011, 2'd0);
        run(3);
        check("late_no_write", wr_log.size(), 0);
        push_data(32'hCAFE_F00D);
        run(10);
        check("late_writes", wr_log.size(), 1);
        if (wr_log.size() == 1) begin
            check("late_addr", {2'b0, wr_log[0].addr}, 32'h3FFFFFFF);
            check("late_be", {28'b0, wr_log[0].be}, 32'h3);
            check("late_data", wr_log[0].data, 32'hCAFE_F00D);
        end
        clear_logs();
        push_data(32'h11);
        push_data(32'h22);
        push_req(1'b0, 1'b0, 30'h3FFFFFFF, 5'd1, 4'b0011, 2'd0);
        run(10);
        check("wrap_writes", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            check("wrap_second_addr", {2'b0, wr_log[1].addr}, 32'h0);
            check("wrap_be", {28'b0, wr_log[0].be}, 32'hF);
            check("wrap_second_data", wr_log[1].data, 32'h22);
        end

`ifdef L2_RESPONDER_RESERVATION_EN
        clear_logs();
        push_req(1'b1, 1'b1, 30'h40, 5'b00010, 4'hF, 2'd0);
        run(10);
        push_data(32'hAAAA_0001);
        push_req(1'b0, 1'b1, 30'h40, 5'b00011, 4'hF, 2'd0);
        run(10);
        check("sc_ok_pulses", con_pulses, 1);
        check("sc_ok_result", {31'b0, last_con_result}, 32'd1);
        check("sc_ok_writes", wr_log.size(), 1);
        if (wr_log.size() == 1) check("sc_ok_addr", {2'b0, wr_log[0].addr}, 32'h40);
        clear_logs();
        push_req(1'b1, 1'b1, 30'h40, 5'b00010, 4'hF, 2'd0);
        run(10);
        push_data(32'hB1);
        push_req(1'b0, 1'b0, 30'h40, 5'd0, 4'hF, 2'd0);
        run(10);
        push_data(32'hB2);
        push_req(1'b0, 1'b1, 30'h40, 5'b00011, 4'hF, 2'd0);
        run(10);
        check("sc_fail_pulses", con_pulses, 1);
        check("sc_fail_result", {31'b0, last_con_result}, 32'd0);
        check("sc_fail_writes", wr_log.size(), 1);
        push_data(32'hB3);
        push_req(1'b0, 1'b0, 30'h44, 5'd0, 4'hF, 2'd0);
        run(10);
        check("sc_fail_popped", wr_log.size(), 2);
        if (wr_log.size() == 2) check("sc_fail_next_data", wr_log[1].data, 32'hB3);
`else
        clear_logs();
        push_data(32'hAAAA_0001);
        push_req(1'b0, 1'b1, 30'h40, 5'b00011, 4'hF, 2'd0);
        run(10);
        check("nores_pulses", con_pulses, 0);
        check("nores_writes", wr_log.size(), 1);
        if (wr_log.size() == 1) check("nores_data", wr_log[0].data, 32'hAAAA_0001);
`endif

        // Asynchronous reset in the middle of an 8-beat read.
        clear_logs();
        push_req(1'b1, 1'b0, 30'h800, 5'd7, 4'hF, 2'd3);
        for (int i = 0; i < 20 && word_log.size() < 2; i++) tick();
        check("mid_rst_started", {31'b0, rd_data_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_ctrl", {25'b0, rd_data_valid, mem_en, mem_we, request_full, data_full, con_valid, con_result}, 32'h0);
        check("mid_rst_rd_data", rd_data, 32'h0);
        check("mid_rst_mem", {mem_addr, rd_sub_id}, 32'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_quiet", {30'b0, rd_data_valid, mem_en}, 32'h0);
        tick();
        clear_logs();
        push_req(1'b1, 1'b0, 30'h900, 5'd2, 4'hF, 2'd2);
        run(20);
        check("post_rst_words", word_log.size(), 3);
        if (word_log.size() == 3) begin
            check("post_rst_first", word_log[0].data, rd_val(30'h900));
            check("post_rst_last", word_log[2].data, rd_val(30'h902));
            check("post_rst_tag", {30'b0, word_log[2].sub}, 32'd2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
